// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_gen
//  Description : VGA raster timing generator. Advances horizontal/vertical
//                counters on each single-cycle pixel enable and produces
//                registered hsync, vsync, active-video and line/frame start
//                strobes that are always consistent with the counters shown.
//  Option      : define VGA_FRAME_COUNT_EN to add the 8-bit frame_cnt output.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b0
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       pix_en,
    output logic [9:0] hc,
    output logic [9:0] vc,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic       line_start,
    output logic       frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    // Derived line/frame geometry
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 10-bit boundaries so every compare below is width-matched
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    // The counters are 10 bits wide; reject geometries that would overflow them
    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_geometry
            $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
        end
    endgenerate

    logic       w_h_wrap;
    logic       w_v_wrap;
    logic       w_frame_wrap;
    logic [9:0] w_hc_next;
    logic [9:0] w_vc_next;
    logic       w_hs_on;
    logic       w_vs_on;
    logic       w_active_next;

    // Next raster position and the region decode of that position; the
    // registers below load these together so sync/active never lag hc/vc
    always_comb begin
        w_h_wrap      = (hc == H_LAST);
        w_v_wrap      = (vc == V_LAST);
        w_frame_wrap  = w_h_wrap && w_v_wrap;
        w_hc_next     = w_h_wrap ? 10'd0 : hc + 10'd1;
        w_vc_next     = vc;
        if (w_h_wrap) begin
            w_vc_next = w_v_wrap ? 10'd0 : vc + 10'd1;
        end
        w_hs_on       = (w_hc_next >= HS_FIRST) && (w_hc_next <= HS_LAST);
        w_vs_on       = (w_vc_next >= VS_FIRST) && (w_vc_next <= VS_LAST);
        w_active_next = (w_hc_next < H_ACT_END) && (w_vc_next < V_ACT_END);
    end

    // Raster state: reset parks on the last pixel of the last line so the
    // first enable lands on (0,0) and produces a clean frame edge
    always_ff @(posedge clk) begin
        if (clr) begin
            hc          <= H_LAST;
            vc          <= V_LAST;
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            active      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            hc          <= w_hc_next;
            vc          <= w_vc_next;
            hsync       <= w_hs_on ? H_POL : ~H_POL;
            vsync       <= w_vs_on ? V_POL : ~V_POL;
            active      <= w_active_next;
            line_start  <= w_h_wrap;
            frame_start <= w_frame_wrap;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic r_seen_frame;

    // Completed-frame count: the frame edge straight after reset opens frame 0
    // and is not counted; every later frame edge bumps the count (mod 256)
    always_ff @(posedge clk) begin
        if (clr) begin
            frame_cnt    <= 8'd0;
            r_seen_frame <= 1'b0;
        end else if (pix_en && w_frame_wrap) begin
            r_seen_frame <= 1'b1;
            if (r_seen_frame) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_sync_gen
//  Description : Self-checking bench for vga_sync_gen. Drives a default
//                640x480 instance and a small-geometry instance from the same
//                stimulus and compares both against a tick-count raster model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

    // Small geometry: 8+2+3+3 = 16 pixels, 6+1+2+1 = 10 lines, 160 ticks/frame
    localparam int SH_A = 8,  SH_FP = 2, SH_S = 3, SH_BP = 3;
    localparam int SV_A = 6,  SV_FP = 1, SV_S = 2, SV_BP = 1;
    localparam int SHT  = SH_A + SH_FP + SH_S + SH_BP;
    localparam int SVT  = SV_A + SV_FP + SV_S + SV_BP;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       pix_en = 1'b0;

    logic [9:0] d_hc, d_vc, s_hc, s_vc;
    logic       d_hs, d_vs, d_act, d_ls, d_fs;
    logic       s_hs, s_vs, s_act, s_ls, s_fs;
    logic [7:0] d_fc, s_fc;

    int checks = 0;
    int errors = 0;

    // Reference state: number of pixel ticks since reset (-1 = reset state)
    int t   = -1;
    bit adv = 1'b0;

    vga_sync_gen dut_d (
        .clk(clk), .clr(clr), .pix_en(pix_en),
        .hc(d_hc), .vc(d_vc), .hsync(d_hs), .vsync(d_vs), .active(d_act),
        .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_cnt(d_fc)
`endif
    );

    vga_sync_gen #(
        .H_ACTIVE(SH_A), .H_FP(SH_FP), .H_SYNC(SH_S), .H_BP(SH_BP),
        .V_ACTIVE(SV_A), .V_FP(SV_FP), .V_SYNC(SV_S), .V_BP(SV_BP)
    ) dut_s (
        .clk(clk), .clr(clr), .pix_en(pix_en),
        .hc(s_hc), .vc(s_vc), .hsync(s_hs), .vsync(s_vs), .active(s_act),
        .line_start(s_ls), .frame_start(s_fs)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_cnt(s_fc)
`endif
    );

`ifndef VGA_FRAME_COUNT_EN
    assign d_fc = 8'd0;
    assign s_fc = 8'd0;
`endif

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (tick %0d)", tag, obs, exp, t);
        end
    endtask

    // Compare one instance against the raster position implied by tick count t
    task automatic check_inst(input string n, input int ha, input int hfp, input int hs,
                              input int hbp, input int va, input int vfp, input int vs,
                              input int vbp,
                              input logic [9:0] hc, input logic [9:0] vc,
                              input logic hsy, input logic vsy, input logic act,
                              input logic ls, input logic fs, input logic [7:0] fc);
        int ht, vt, eh, ev;
        ht = ha + hfp + hs + hbp;
        vt = va + vfp + vs + vbp;
        eh = (t < 0) ? ht - 1 : t % ht;
        ev = (t < 0) ? vt - 1 : (t / ht) % vt;
        chk({n, ".hc"}, 32'(hc), 32'(eh));
        chk({n, ".vc"}, 32'(vc), 32'(ev));
        chk({n, ".hsync"}, 32'(hsy), 32'((eh >= ha + hfp && eh < ha + hfp + hs) ? 0 : 1));
        chk({n, ".vsync"}, 32'(vsy), 32'((ev >= va + vfp && ev < va + vfp + vs) ? 0 : 1));
        chk({n, ".active"}, 32'(act), 32'((t >= 0 && eh < ha && ev < va) ? 1 : 0));
        chk({n, ".line_start"}, 32'(ls), 32'((adv && eh == 0) ? 1 : 0));
        chk({n, ".frame_start"}, 32'(fs), 32'((adv && eh == 0 && ev == 0) ? 1 : 0));
`ifdef VGA_FRAME_COUNT_EN
        chk({n, ".frame_cnt"}, 32'(fc), 32'((t < 0) ? 0 : (t / (ht * vt)) % 256));
`endif
    endtask

    // One clock: drive at the falling edge, update the model at the rising
    // edge, then compare both instances 1 ns later
    task automatic tick(input bit c, input bit e);
        @(negedge clk);
        clr    = c;
        pix_en = e;
        @(posedge clk);
        if (c) begin
            t   = -1;
            adv = 1'b0;
        end else if (e) begin
            t++;
            adv = 1'b1;
        end else begin
            adv = 1'b0;
        end
        #1;
        check_inst("def", 640, 16, 96, 48, 480, 10, 2, 33,
                   d_hc, d_vc, d_hs, d_vs, d_act, d_ls, d_fs, d_fc);
        check_inst("small", SH_A, SH_FP, SH_S, SH_BP, SV_A, SV_FP, SV_S, SV_BP,
                   s_hc, s_vc, s_hs, s_vs, s_act, s_ls, s_fs, s_fc);
    endtask

    initial begin
        int act_cnt, hs_cnt, hs_first, ls_first, ls_gap;
        int vs_cnt, vs_first, fs_prev, fs_gap, vmax;
        bit found;
        logic [9:0] hold_hc;

        // Reset overrides pix_en
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        chk("reset.hc", 32'(d_hc), 32'd799);
        chk("reset.vc", 32'(d_vc), 32'd524);

        // pix_en every 4th clk across one full default line
        act_cnt = 0; hs_cnt = 0; hs_first = -1; ls_first = -1; ls_gap = -1;
        for (int i = 0; i < 4000 && t < 800; i++) begin
            tick(1'b0, (i % 4) == 3);
            if (adv && t == 0) begin
                chk("first.hc", 32'(d_hc), 32'd0);
                chk("first.active", 32'(d_act), 32'd1);
                chk("first.frame_start", 32'(d_fs), 32'd1);
            end
            if (adv && t >= 0 && t < 800) begin
                if (d_act) act_cnt++;
                if (!d_hs) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = int'(d_hc);
                end
            end
            if (d_ls) begin
                if (ls_first < 0) ls_first = t;
                else if (ls_gap < 0) ls_gap = t - ls_first;
            end
        end
        chk("line.active_ticks", 32'(act_cnt), 32'd640);
        chk("line.hsync_ticks", 32'(hs_cnt), 32'd96);
        chk("line.hsync_start", 32'(hs_first), 32'd656);
        chk("line.ls_period", 32'(ls_gap), 32'd800);

        // Random pix_en with occasional resets
        for (int i = 0; i < 2000; i++) begin
            tick(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 40));
        end
        // Advance a little, then hold pix_en low for 1000 clks mid-line
        for (int i = 0; i < 37; i++) tick(1'b0, 1'b1);
        hold_hc = d_hc;
        for (int i = 0; i < 1000; i++) tick(1'b0, 1'b0);
        chk("hold.hc", 32'(d_hc), 32'(hold_hc));

        // Reset arriving together with pix_en at hc=300: reset must win
        tick(1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            tick(1'b0, 1'b1);
            if (d_hc == 10'd300) found = 1'b1;
        end
        chk("reach_hc300", 32'(found), 32'd1);
        tick(1'b1, 1'b1);
        chk("clr_wins.hc", 32'(d_hc), 32'd799);
        chk("clr_wins.fs", 32'(d_fs), 32'd0);
        tick(1'b0, 1'b1);
        chk("after_clr.frame_start", 32'(d_fs), 32'd1);

        // pix_en tied high for 257 small frames (frame counter wrap)
        vs_cnt = 0; vs_first = -1; fs_prev = 0; fs_gap = -1; vmax = 0;
        for (int i = 0; i < 257 * SHT * SVT + 5; i++) begin
            tick(1'b0, 1'b1);
            if (int'(s_vc) > vmax) vmax = int'(s_vc);
            if (t >= SHT * SVT && t < 2 * SHT * SVT && !s_vs) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = int'(s_vc);
            end
            if (s_fs && t > 0 && fs_gap < 0) fs_gap = t - fs_prev;
        end
        chk("frame.vsync_lines", 32'(vs_cnt / SHT), 32'(SV_S));
        chk("frame.vsync_ticks", 32'(vs_cnt), 32'(SV_S * SHT));
        chk("frame.vsync_start", 32'(vs_first), 32'(SV_A + SV_FP));
        chk("frame.fs_period", 32'(fs_gap), 32'(SHT * SVT));
        chk("frame.vc_max", 32'(vmax), 32'(SVT - 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
